// File: rtl/store_pack_pkg.sv
// ---------------------------------------------------------------------------
// store_pack_pkg
// Shared constants and types for the store-side data-memory interface.
//   SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD : encodings of the st_size field
//   BE_ALL                                : all four byte lanes enabled
//   state_t                               : IDLE / BUSY write-channel state
// ---------------------------------------------------------------------------
package store_pack_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [3:0] BE_ALL  = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/store_pack_if.sv
// ---------------------------------------------------------------------------
// store_pack_if
// Bundles the MEM-stage store request channel and the data-memory write bus.
//   st_valid/st_size/st_addr/st_data : store request from the MEM stage
//   st_ready/stall                   : acceptance and upstream freeze
//   st_err/bad_addr                  : rejected-store pulse and its address
//   mem_req/mem_addr/mem_wdata/mem_be: write request toward data memory
//   mem_ack                          : memory took the write this cycle
// modport slave  : the store pack unit itself
// modport master : its environment (MEM stage plus the data memory)
// ---------------------------------------------------------------------------
interface store_pack_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic                  st_valid;
    logic [1:0]            st_size;
    logic [ADDR_W-1:0]     st_addr;
    logic [DATA_W-1:0]     st_data;
    logic                  st_ready;
    logic                  stall;
    logic                  st_err;
    logic [ADDR_W-1:0]     bad_addr;
    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_ack;

    modport slave (
        input  st_valid, st_size, st_addr, st_data, mem_ack,
        output st_ready, stall, st_err, bad_addr,
               mem_req, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output st_valid, st_size, st_addr, st_data, mem_ack,
        input  st_ready, stall, st_err, bad_addr,
               mem_req, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/store_lane_pack.sv
// ---------------------------------------------------------------------------
// store_lane_pack
// Purely combinational lane packer: narrows/replicates store data into the
// little-endian byte lanes of a 32-bit bus and reports natural alignment.
//   size    in  2   SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD
//   addr    in  2   low byte-address bits (lane offset)
//   data    in  32  register value; low bits significant for byte/half
//   wdata   out 32  lane-replicated write data
//   be      out 4   byte enables, bit i = byte lane i
//   aligned out 1   store is naturally aligned and of a legal size
// The lane selection is kept separate so the load-extract path can reuse it.
// ---------------------------------------------------------------------------
module store_lane_pack
    import store_pack_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        aligned
);

    // Replicating the narrow value across every lane means the memory only
    // has to look at the byte enables to pick the right bytes.  The reserved
    // size falls through to the defaults: no lanes, never aligned.
    always_comb begin
        wdata   = data;
        be      = 4'b0000;
        aligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                wdata   = {4{data[7:0]}};
                be      = 4'b0001 << addr;
                aligned = 1'b1;
            end
            SZ_HALF: begin
                wdata   = {2{data[15:0]}};
                be      = addr[1] ? 4'b1100 : 4'b0011;
                aligned = ~addr[0];
            end
            SZ_WORD: begin
                wdata   = data;
                be      = BE_ALL;
                aligned = (addr == 2'b00);
            end
            default: begin
                wdata   = data;
                be      = 4'b0000;
                aligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_pack_unit.sv
// ---------------------------------------------------------------------------
// store_pack_unit
// Store-side data-memory interface for the CPU datapath.  Accepts SB/SH/SW
// from the MEM stage, packs data into byte lanes, issues one req/ack write
// and stalls upstream until the write is taken.  Misaligned or reserved-size
// stores are rejected with a one-cycle st_err pulse and no bus activity.
//   clk  in  rising-edge clock
//   rst  in  synchronous, active-high reset
//   bus  store_pack_if.slave (request channel, status, write bus)
// Build option: define STORE_PACK_BACK2BACK_EN to accept a new store in the
// cycle the current write is acknowledged, keeping mem_req high with no gap.
// ---------------------------------------------------------------------------
module store_pack_unit
    import store_pack_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic          clk,
    input  logic          rst,
    store_pack_if.slave   bus
);

    localparam int LANES = DATA_W / 8;

    state_t               state;
    logic                 mem_req_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic [LANES-1:0]     mem_be_q;
    logic                 st_err_q;
    logic [ADDR_W-1:0]    bad_addr_q;

    logic [31:0]          lane_wdata;
    logic [3:0]           lane_be;
    logic                 lane_aligned;
    logic                 st_ready_c;
    logic                 accept;

    store_lane_pack u_lane_pack (
        .size    (bus.st_size),
        .addr    (bus.st_addr[1:0]),
        .data    (bus.st_data),
        .wdata   (lane_wdata),
        .be      (lane_be),
        .aligned (lane_aligned)
    );

    // Readiness: normally only when idle; with back-to-back enabled the ack
    // cycle also frees the slot, because the held payload leaves at that edge.
`ifdef STORE_PACK_BACK2BACK_EN
    assign st_ready_c = (state == IDLE) | ((state == BUSY) & bus.mem_ack);
`else
    assign st_ready_c = (state == IDLE);
`endif

    assign accept = bus.st_valid & st_ready_c;

    // Single FSM block.  Every bus-facing output is a register so memory sees
    // a stable address/data/enable for the whole BUSY period.  Rejected
    // stores never leave IDLE; they just pulse st_err on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            st_err_q    <= 1'b0;
            bad_addr_q  <= '0;
        end else begin
            st_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (lane_aligned) begin
                            state       <= BUSY;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {bus.st_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= lane_wdata;
                            mem_be_q    <= lane_be;
                        end else begin
                            st_err_q   <= 1'b1;
                            bad_addr_q <= bus.st_addr;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ack) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
`ifdef STORE_PACK_BACK2BACK_EN
                        // A store accepted on the ack edge replaces the
                        // payload immediately; a bad one still ends the write.
                        if (accept) begin
                            if (lane_aligned) begin
                                state       <= BUSY;
                                mem_req_q   <= 1'b1;
                                mem_addr_q  <= {bus.st_addr[ADDR_W-1:2], 2'b00};
                                mem_wdata_q <= lane_wdata;
                                mem_be_q    <= lane_be;
                            end else begin
                                st_err_q   <= 1'b1;
                                bad_addr_q <= bus.st_addr;
                            end
                        end
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.st_ready  = st_ready_c;
    assign bus.stall     = bus.st_valid & ~st_ready_c;
    assign bus.st_err    = st_err_q;
    assign bus.bad_addr  = bad_addr_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_store_pack_unit.sv
// ---------------------------------------------------------------------------
// tb_store_pack_unit
// Directed bench for store_pack_unit.  Expected writes and expected error
// addresses are queued as stores are issued; a monitor pops and compares them
// whenever the unit completes a write or pulses st_err.  A memory responder
// acknowledges each write after a per-write delay taken from its own queue.
// ---------------------------------------------------------------------------
module tb_store_pack_unit;
    import store_pack_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_t;

`ifdef STORE_PACK_BACK2BACK_EN
    localparam int SH_STALLS  = 1;
    localparam int B2B_STALLS = 0;
    localparam bit B2B_REQ1   = 1'b1;
    localparam bit B2B_REQ2   = 1'b0;
    localparam int SECOND_IDX = 1;
`else
    localparam int SH_STALLS  = 2;
    localparam int B2B_STALLS = 1;
    localparam bit B2B_REQ1   = 1'b0;
    localparam bit B2B_REQ2   = 1'b1;
    localparam int SECOND_IDX = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    logic mem_ack_drv = 1'b0;
    bit   idle_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    wr_t         wq[$];
    logic [31:0] eq[$];
    int          delay_q[$];
    logic        req_log[$];
    logic [31:0] addr_log[$];

    always #5 clk = ~clk;

    store_pack_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    assign bus.mem_ack = mem_ack_drv;

    store_pack_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input int delay);
        wr_t w;
        w.addr  = addr;
        w.wdata = wdata;
        w.be    = be;
        wq.push_back(w);
        delay_q.push_back(delay);
    endtask

    // Presents one store and holds it until accepted; returns just after the
    // accepting edge with st_valid dropped, plus the number of stall cycles.
    task automatic apply_stimulus(input logic [1:0] size, input logic [31:0] addr,
                                  input logic [31:0] data, output int stall_cycles);
        bit taken;
        taken        = 1'b0;
        stall_cycles = 0;
        bus.st_valid = 1'b1;
        bus.st_size  = size;
        bus.st_addr  = addr;
        bus.st_data  = data;
        for (int i = 0; i < 20 && !taken; i++) begin
            @(negedge clk);
            if (bus.st_ready === 1'b1) taken = 1'b1;
            else if (bus.stall === 1'b1) stall_cycles++;
            tick();
        end
        bus.st_valid = 1'b0;
        check_output("accepted", {31'd0, taken}, 32'd1);
    endtask

    // Memory model: acks each write after the delay queued for it.
    int cur_delay = 0;
    int cnt = 0;
    bit active = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (bus.mem_req !== 1'b1) begin
            active      = 1'b0;
            mem_ack_drv = idle_ack;
        end else begin
            if (!active) begin
                active    = 1'b1;
                cnt       = 0;
                cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
            end
            mem_ack_drv = (cnt == cur_delay);
            if (mem_ack_drv) active = 1'b0;
            else cnt++;
        end
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            req_log.push_back(bus.mem_req);
            addr_log.push_back(bus.mem_addr);
            if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b1) begin
                if (wq.size() == 0) begin
                    check_output("unexpected_write", bus.mem_addr, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check_output("wr_addr", bus.mem_addr, e.addr);
                    check_output("wr_wdata", bus.mem_wdata, e.wdata);
                    check_output("wr_be", {28'd0, bus.mem_be}, {28'd0, e.be});
                end
            end
            if (bus.st_err === 1'b1) begin
                if (eq.size() == 0) check_output("unexpected_err", bus.bad_addr, 32'hFFFF_FFFF);
                else check_output("bad_addr", bus.bad_addr, eq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the sequence finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          stalls;
        logic [7:0]  lane_byte;
        logic [1:0]  err_size [3];
        logic [31:0] err_addr [3];

        err_size = '{SZ_WORD, SZ_HALF, SZ_RSVD};
        err_addr = '{32'h3001, 32'h3001, 32'h3000};

        bus.st_valid = 1'b0;
        bus.st_size  = 2'b00;
        bus.st_addr  = 32'd0;
        bus.st_data  = 32'd0;
        rst          = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_output("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check_output("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
        check_output("rst_mem_addr", bus.mem_addr, 32'd0);
        check_output("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check_output("rst_st_ready", {31'd0, bus.st_ready}, 32'd1);
        check_output("rst_stall", {31'd0, bus.stall}, 32'd0);
        check_output("rst_st_err", {31'd0, bus.st_err}, 32'd0);
        check_output("rst_bad_addr", bus.bad_addr, 32'd0);
        tick();

        // SB with ack on second BUSY cycle, then SH acked in its first cycle
        $display("[TB] SB 0x1003 then SH 0x2002");
        expect_write(32'h1000, 32'hDDDD_DDDD, 4'b1000, 1);
        apply_stimulus(SZ_BYTE, 32'h1003, 32'hAABB_CCDD, stalls);
        check_output("sb_stalls", stalls, 32'd0);
        expect_write(32'h2000, 32'h5678_5678, 4'b1100, 0);
        apply_stimulus(SZ_HALF, 32'h2002, 32'h1234_5678, stalls);
        check_output("sh_stalls", stalls, SH_STALLS);
        @(negedge clk);
        check_output("sh_req", {31'd0, bus.mem_req}, 32'd1);
        check_output("sh_wdata", bus.mem_wdata, 32'h5678_5678);
        check_output("sh_be", {28'd0, bus.mem_be}, 32'hC);
        tick();
        @(negedge clk);
        check_output("sh_req_one_cycle", {31'd0, bus.mem_req}, 32'd0);
        tick();

        // Rejected stores
        $display("[TB] misaligned and reserved-size stores");
        for (int k = 0; k < 3; k++) begin
            eq.push_back(err_addr[k]);
            apply_stimulus(err_size[k], err_addr[k], 32'h0BAD_0BAD, stalls);
            @(negedge clk);
            check_output("err_pulse", {31'd0, bus.st_err}, 32'd1);
            check_output("err_no_req", {31'd0, bus.mem_req}, 32'd0);
            check_output("err_bad_addr", bus.bad_addr, err_addr[k]);
            tick();
            @(negedge clk);
            check_output("err_one_cycle", {31'd0, bus.st_err}, 32'd0);
            check_output("err_still_no_req", {31'd0, bus.mem_req}, 32'd0);
            tick();
        end

        // Reset while BUSY with no ack, then a normal SW
        $display("[TB] reset mid-write");
        delay_q.push_back(1000);
        apply_stimulus(SZ_WORD, 32'h5000, 32'h55AA_55AA, stalls);
        @(negedge clk);
        check_output("busy_before_rst", {31'd0, bus.mem_req}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_busy_req", {31'd0, bus.mem_req}, 32'd0);
        check_output("rst_busy_be", {28'd0, bus.mem_be}, 32'd0);
        check_output("rst_busy_ready", {31'd0, bus.st_ready}, 32'd1);
        tick();
        expect_write(32'h4000, 32'h0102_0304, BE_ALL, 1);
        apply_stimulus(SZ_WORD, 32'h4000, 32'h0102_0304, stalls);
        @(negedge clk);
        check_output("sw_after_rst_addr", bus.mem_addr, 32'h4000);
        tick();
        tick();

        // Two consecutive SWs, ack every cycle
        $display("[TB] consecutive SW 0x10 / 0x14");
        expect_write(32'h10, 32'h1111_1111, BE_ALL, 0);
        expect_write(32'h14, 32'h2222_2222, BE_ALL, 0);
        apply_stimulus(SZ_WORD, 32'h10, 32'h1111_1111, stalls);
        req_log.delete();
        addr_log.delete();
        apply_stimulus(SZ_WORD, 32'h14, 32'h2222_2222, stalls);
        check_output("b2b_stalls", stalls, B2B_STALLS);
        tick();
        @(negedge clk);
        check_output("b2b_req0", {31'd0, req_log[0]}, 32'd1);
        check_output("b2b_req1", {31'd0, req_log[1]}, {31'd0, B2B_REQ1});
        check_output("b2b_req2", {31'd0, req_log[2]}, {31'd0, B2B_REQ2});
        check_output("b2b_second_addr", addr_log[SECOND_IDX], 32'h14);
        tick();

        // mem_ack while IDLE must be ignored
        $display("[TB] idle ack then SW 0x20");
        @(negedge clk);
        idle_ack = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check_output("idle_ack_no_req", {31'd0, bus.mem_req}, 32'd0);
        check_output("idle_ack_ready", {31'd0, bus.st_ready}, 32'd1);
        idle_ack = 1'b0;
        tick();
        tick();
        expect_write(32'h20, 32'hCAFE_BABE, BE_ALL, 0);
        apply_stimulus(SZ_WORD, 32'h20, 32'hCAFE_BABE, stalls);
        @(negedge clk);
        check_output("sw20_be", {28'd0, bus.mem_be}, 32'hF);
        check_output("sw20_wdata", bus.mem_wdata, 32'hCAFE_BABE);
        tick();

        // Byte lanes at every offset, and a low halfword
        $display("[TB] byte lane sweep");
        for (int i = 0; i < 4; i++) begin
            lane_byte = 8'hA0 + 8'(i);
            expect_write(32'h100, {4{lane_byte}}, 4'(4'b0001 << i), i % 2);
            apply_stimulus(SZ_BYTE, 32'h100 + 32'(i), {24'h123456, lane_byte}, stalls);
            tick();
            tick();
        end
        expect_write(32'h200, 32'hBEEF_BEEF, 4'b0011, 0);
        apply_stimulus(SZ_HALF, 32'h200, 32'h0000_BEEF, stalls);
        tick();
        tick();
        tick();

        check_output("writes_drained", wq.size(), 32'd0);
        check_output("errs_drained", eq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
